adc_serial_rx: RTL and testbench
================================

# adc_serial_rx

Parametrised serial ADC receiver for Pmod-style converters (AD7476-class) with one shared CS/SCLK and CH parallel data lines. It generates SCLK internally from clk and captures CH words per frame, MSB first. It delivers them on a single-clk-wide `valid` strobe in the clk domain, so downstream logic needs no edge-counting resynchroniser. It supports single-shot and continuous conversion and sits between the Pmod pins and the servo control datapath.

## Interface
- `DATA_W`, 12: result bits per channel
- `LEAD_BITS`, 4: leading bits per frame, sent by the ADC before the MSB
- `CH`, 2: number of data lines sharing CS/SCLK
- `CLK_DIV`, 4: SCLK half-period in clk cycles (≥2)
- `QUIET_CYC`, 4: minimum clk cycles CS stays high between frames (≥1)
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-shot request, sampled in IDLE only
- `cont`  in  1  continuous mode: back-to-back frames while high
- `sdata`  in  CH  serial data, bit c = channel c
- `cs`  out  1  ADC chip select, active-low
- `sclk`  out  1  ADC serial clock, idles high
- `dout`  out  CH*DATA_W  results, channel c in bits [c*DATA_W +: DATA_W]
- `valid`  out  1  one-clk pulse: `dout` updated this cycle
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  leading-bit error, qualified by `valid`

## Operation
- FRAME_W = LEAD_BITS + DATA_W SCLK rising edges per frame.
- FSM states: IDLE, CS_SETUP, SHIFT, DONE, QUIET.
- IDLE: cs=1, sclk=1. Enter CS_SETUP when `start` or `cont` is high.
- CS_SETUP: cs=0, sclk=1, lasts CLK_DIV cycles, then SHIFT.
- SHIFT:
  - sclk falls on entry and toggles every CLK_DIV cycles.
  - On each rising-edge cycle (sclk register 0→1), `sdata[c]` is shifted into shift register c, MSB first.
  - After the FRAME_W-th rise, go to DONE. sclk stays high.
- DONE, one cycle:
  - cs=1.
  - `dout` loads the low DATA_W bits of each shift register.
  - `valid`=1.
  - `err` is driven per Configuration.
- QUIET: cs=1 for QUIET_CYC cycles. Then go to CS_SETUP if `cont`=1, else IDLE.
- `start` outside IDLE is ignored, not queued.
- Dropping `cont` mid-frame completes the current frame, then returns to IDLE.
- `dout` holds its value between `valid` pulses.
- Async reset, including mid-frame:
  - cs=1, sclk=1, valid=0, err=0, busy=0, dout=0, state=IDLE.
  - The partial frame is discarded and produces no `valid`.

## Timing
- All outputs are registered, with no combinational input→output paths.
- `start` seen in cycle 0 → cs low from cycle 1. The k-th sclk rise is at cycle CLK_DIV+1+(2k−1)·CLK_DIV.
- `valid` appears at cycle 2·FRAME_W·CLK_DIV+2; with defaults this is cycle 130.
- Continuous frame period (cs fall to cs fall) is 2·FRAME_W·CLK_DIV+QUIET_CYC+2 cycles; with defaults this is 134.
- SCLK low time = high time = CLK_DIV cycles. ADC data changes after sclk falls and is sampled at the rise.

## Configuration
- `ADC_SERIAL_RX_LEAD_CHECK_EN` defined:
  - the leading LEAD_BITS of every channel are compared against zero;
  - `err`=1 in the DONE cycle if any channel has a nonzero leading bit, else 0.
- Not defined:
  - leading bits are shifted and discarded;
  - `err` is tied to 0;
  - no compare logic is synthesised.

## Structure
- Package `adc_rx_pkg` holds:
  - the state encoding constants for IDLE, CS_SETUP, SHIFT, DONE and QUIET;
  - the FRAME_W derivation helper.
- Sub-module `adc_sclk_gen`:
  - clk divider producing the registered `sclk` and a one-cycle `rise_tick`;
  - enabled only in SHIFT;
  - its counter is cleared on enable deassertion.

## Test plan
- Defaults, pulse `start`, ADC model sends ch0=0xA5C, ch1=0x3F1 with zero lead bits → `valid` at cycle 130 with dout={0x3F1,0xA5C}; 16 sclk rises; cs low for cycles 1..129.
- `cont`=1 for 3 frames with values 0x001, 0x800, 0xFFF → 3 `valid` pulses spaced 134 cycles apart; values in order; cs high ≥4 cycles between frames.
- `start` pulsed again at cycle 50 of a frame → ignored, exactly one `valid`, `busy` high throughout.
- `rst` asserted at cycle 70 mid-frame → cs=1 and sclk=1 immediately, no `valid`, dout=0. A following `start` yields a correct frame.
- Macro defined, ch1 lead bits = 4'b0100 → `err`=1 with `valid`. Macro undefined, same stimulus → `err`=0 and data unchanged.
- CLK_DIV=2, DATA_W=10, LEAD_BITS=6, CH=1 → `valid` at cycle 66; the 10-bit word 0x2AA is captured correctly.

Source files
------------

// File: rtl/adc_serial_rx_pkg.sv
// Shared types and helpers for the serial ADC receiver.
// State encoding and frame-length derivation live here so all files agree.
package adc_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_QUIET
  } state_t;

  function automatic int unsigned frame_w(input int unsigned lead_bits,
                                          input int unsigned data_w);
    return lead_bits + data_w;
  endfunction

endpackage

// File: rtl/adc_serial_rx_if.sv
// Control/result bundle between the ADC receiver and the servo datapath.
interface adc_serial_rx_if #(
  parameter int unsigned CH     = 2,
  parameter int unsigned DATA_W = 12
);
  logic                 start;
  logic                 cont;
  logic [CH*DATA_W-1:0] dout;
  logic                 valid;
  logic                 busy;
  logic                 err;

  modport master (output start, cont, input dout, valid, busy, err);
  modport slave  (input start, cont, output dout, valid, busy, err);
endinterface

// File: rtl/adc_serial_rx_sclk_gen.sv
// SCLK divider: idles high, falls on the first enabled cycle, then toggles
// every CLK_DIV clk cycles; rise_tick marks the first cycle sclk reads high.
module adc_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick
);
  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sclk      <= 1'b1;
      rise_tick <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      sclk      <= 1'b1;
      rise_tick <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      // Toggling on cnt==0 makes the fall land on the very first enabled edge.
      if (cnt == '0) begin
        sclk      <= ~sclk;
        rise_tick <= ~sclk;
      end
      cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_serial_rx.sv
// Serial ADC receiver: shared CS/SCLK, CH data lines, MSB-first capture.
// Define ADC_SERIAL_RX_LEAD_CHECK_EN to flag nonzero leading bits on err.
module adc_serial_rx
  import adc_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned LEAD_BITS = 4,
  parameter int unsigned CH        = 2,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned QUIET_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  adc_serial_rx_if.slave bus,
  input  logic [CH-1:0] sdata,
  output logic          cs,
  output logic          sclk
);
  localparam int unsigned FRAME_W  = frame_w(LEAD_BITS, DATA_W);
`ifdef ADC_SERIAL_RX_LEAD_CHECK_EN
  localparam int unsigned SR_W     = FRAME_W;
`else
  localparam int unsigned SR_W     = DATA_W;
`endif
  localparam int unsigned WAIT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned BIT_W    = $clog2(FRAME_W + 1);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SR_W-1:0]   shreg  [CH];
  logic [SR_W-1:0]   sh_nxt [CH];
  logic              sclk_en;
  logic              rise_tick;
  logic              lead_err;

  // Driven from next state so sclk falls in the first SHIFT cycle.
  assign sclk_en = (state_n == ST_SHIFT);

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (sclk_en),
    .sclk      (sclk),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (bus.start || bus.cont) state_n = ST_CS_SETUP;
      ST_CS_SETUP: if (wait_cnt == WAIT_W'(CLK_DIV - 1)) state_n = ST_SHIFT;
      ST_SHIFT:    if (rise_tick && bit_cnt == BIT_W'(FRAME_W - 1)) state_n = ST_DONE;
      ST_DONE:     state_n = ST_QUIET;
      ST_QUIET:    if (wait_cnt == WAIT_W'(QUIET_CYC - 1))
                     state_n = bus.cont ? ST_CS_SETUP : ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    lead_err = 1'b0;
    for (int unsigned c = 0; c < CH; c++) begin
      sh_nxt[c] = {shreg[c][SR_W-2:0], sdata[c]};
`ifdef ADC_SERIAL_RX_LEAD_CHECK_EN
      lead_err = lead_err | (|sh_nxt[c][FRAME_W-1 -: LEAD_BITS]);
`endif
    end
  end

  // Outputs are registered from state_n so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      cs        <= 1'b1;
      bus.valid <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
      bus.dout  <= '0;
      for (int unsigned c = 0; c < CH; c++) shreg[c] <= '0;
    end else begin
      if (state_n != state)
        wait_cnt <= '0;
      else if (state == ST_CS_SETUP || state == ST_QUIET)
        wait_cnt <= wait_cnt + 1'b1;

      if (state == ST_SHIFT && rise_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
        for (int unsigned c = 0; c < CH; c++) shreg[c] <= sh_nxt[c];
      end else if (state != ST_SHIFT) begin
        bit_cnt <= '0;
      end

      cs        <= !(state_n == ST_CS_SETUP || state_n == ST_SHIFT);
      bus.busy  <= (state_n != ST_IDLE);
      bus.valid <= (state_n == ST_DONE);
      bus.err   <= (state_n == ST_DONE) && lead_err;
      if (state_n == ST_DONE)
        for (int unsigned c = 0; c < CH; c++)
          bus.dout[c*DATA_W +: DATA_W] <= sh_nxt[c][DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Scoreboard bench for adc_serial_rx: default instance plus a narrow
// CLK_DIV=2 / DATA_W=10 / LEAD_BITS=6 / CH=1 instance.
module tb_adc_serial_rx;
  localparam int DW   = 12;
  localparam int LB   = 4;
  localparam int CHN  = 2;
  localparam int CD   = 4;
  localparam int QC   = 4;
  localparam int FW   = LB + DW;
  localparam int LAT  = 2*FW*CD + 2;
  localparam int PER  = 2*FW*CD + QC + 2;
  localparam int DW2  = 10;
  localparam int LB2  = 6;
  localparam int CD2  = 2;
  localparam int FW2  = LB2 + DW2;
  localparam int LAT2 = 2*FW2*CD2 + 2;

  typedef logic [CHN-1:0][FW-1:0] frame_t;
  typedef struct { logic [CHN*DW-1:0] dout; logic err; int cyc; } exp_t;
  typedef struct { logic [DW2-1:0] dout; logic err; int cyc; } exp2_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sdata = '0;
  logic [0:0] sdata2 = '0;
  logic       cs, sclk, cs2, sclk2;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  frame_t         adc_q[$];
  exp_t           sb[$];
  logic [FW2-1:0] adc2_q[$];
  exp2_t          sb2[$];

  adc_serial_rx_if #(.CH(CHN), .DATA_W(DW))  bus ();
  adc_serial_rx_if #(.CH(1),   .DATA_W(DW2)) bus2 ();

  adc_serial_rx #(.DATA_W(DW), .LEAD_BITS(LB), .CH(CHN), .CLK_DIV(CD), .QUIET_CYC(QC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sdata(sdata), .cs(cs), .sclk(sclk));

  adc_serial_rx #(.DATA_W(DW2), .LEAD_BITS(LB2), .CH(1), .CLK_DIV(CD2), .QUIET_CYC(QC)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .sdata(sdata2), .cs(cs2), .sclk(sclk2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int c = 0; c < CHN; c++) begin
      f[c][DW-1:0]  = DW'($urandom);
      f[c][FW-1:DW] = ($urandom_range(0, 3) == 0) ? LB'($urandom_range(1, 15)) : '0;
    end
    return f;
  endfunction

  function automatic exp_t mk_exp(input frame_t f, input int vcyc);
    exp_t e;
    e.dout = {f[1][DW-1:0], f[0][DW-1:0]};
`ifdef ADC_SERIAL_RX_LEAD_CHECK_EN
    e.err = (f[0][FW-1:DW] != '0) || (f[1][FW-1:DW] != '0);
`else
    e.err = 1'b0;
`endif
    e.cyc = vcyc;
    return e;
  endfunction

  // ADC model + monitor for the default instance
  frame_t            cur;
  int                rises = 0, fall_cyc = 0, rise_cyc = -1000;
  bit                active = 0;
  logic              cs_p = 1'b1, sclk_p = 1'b1;
  logic [CHN*DW-1:0] held = '0;
  exp_t              e;

  always @(negedge clk) begin
    if (rst) begin
      active = 0; sdata = '0; held = '0; rise_cyc = -1000;
    end else begin
      if (cs_p && !cs) begin
        check("quiet_gap_ok", 64'(cyc - rise_cyc >= QC), 64'd1);
        if (adc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame: cs fell with no frame queued (cycle %0d)", cyc);
          cur = '0;
        end else cur = adc_q.pop_front();
        active = 1; rises = 0; fall_cyc = cyc;
        for (int c = 0; c < CHN; c++) sdata[c] = cur[c][FW-1];
      end else if (active) begin
        if (!sclk_p && sclk) rises++;
        if (sclk_p && !sclk && rises < FW)
          for (int c = 0; c < CHN; c++) sdata[c] = cur[c][FW-1-rises];
        if (cs) begin
          active = 0; rise_cyc = cyc;
          check("sclk_rises", 64'(rises), 64'(FW));
          check("cs_low_cycles", 64'(cyc - fall_cyc), 64'(2*FW*CD + 1));
        end
      end
      if (bus.valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid: dout=0x%0h (cycle %0d)", bus.dout, cyc);
        end else begin
          e = sb.pop_front();
          check("dout", bus.dout, e.dout);
          check("err", bus.err, e.err);
          check("valid_cycle", 64'(cyc), 64'(e.cyc));
          held = e.dout;
        end
      end else check("dout_hold", bus.dout, held);
    end
    cs_p = cs; sclk_p = sclk;
  end

  // ADC model + monitor for the narrow instance
  logic [FW2-1:0] cur2;
  int             rises2 = 0;
  bit             active2 = 0;
  logic           cs2_p = 1'b1, sclk2_p = 1'b1;
  logic [DW2-1:0] held2 = '0;
  exp2_t          e2;

  always @(negedge clk) begin
    if (rst) begin
      active2 = 0; sdata2 = '0; held2 = '0;
    end else begin
      if (cs2_p && !cs2) begin
        if (adc2_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame2: cs fell with no frame queued (cycle %0d)", cyc);
          cur2 = '0;
        end else cur2 = adc2_q.pop_front();
        active2 = 1; rises2 = 0; sdata2[0] = cur2[FW2-1];
      end else if (active2) begin
        if (!sclk2_p && sclk2) rises2++;
        if (sclk2_p && !sclk2 && rises2 < FW2) sdata2[0] = cur2[FW2-1-rises2];
        if (cs2) begin
          active2 = 0;
          check("sclk2_rises", 64'(rises2), 64'(FW2));
        end
      end
      if (bus2.valid) begin
        if (sb2.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid2: dout=0x%0h (cycle %0d)", bus2.dout, cyc);
        end else begin
          e2 = sb2.pop_front();
          check("dout2", bus2.dout, e2.dout);
          check("err2", bus2.err, e2.err);
          check("valid2_cycle", 64'(cyc), 64'(e2.cyc));
          held2 = e2.dout;
        end
      end else check("dout2_hold", bus2.dout, held2);
    end
    cs2_p = cs2; sclk2_p = sclk2;
  end

  task automatic single(input frame_t f);
    @(negedge clk);
    adc_q.push_back(f);
    sb.push_back(mk_exp(f, cyc + LAT));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic single2(input logic [FW2-1:0] w);
    exp2_t x;
    @(negedge clk);
    adc2_q.push_back(w);
    x.dout = w[DW2-1:0];
`ifdef ADC_SERIAL_RX_LEAD_CHECK_EN
    x.err = (w[FW2-1:DW2] != '0);
`else
    x.err = 1'b0;
`endif
    x.cyc = cyc + LAT2;
    sb2.push_back(x);
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || sb2.size() != 0 || bus2.busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n >= maxc), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t     f;
    int         s, busy_low;
    logic [11:0] vals [3];
    vals[0] = 12'h001; vals[1] = 12'h800; vals[2] = 12'hFFF;
    bus.start = 0; bus.cont = 0; bus2.start = 0; bus2.cont = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", cs, 1); check("rst_sclk", sclk, 1);
    check("rst_valid", bus.valid, 0); check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0); check("rst_dout", bus.dout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed single shot, then random frames
    f[0] = {4'h0, 12'hA5C}; f[1] = {4'h0, 12'h3F1};
    single(f); drain(400);
    repeat (4) begin single(rand_frame()); drain(400); end

    // Nonzero lead bits on channel 1
    f[0] = {4'h0, 12'h5A5}; f[1] = {4'b0100, 12'h123};
    single(f); drain(400);

    // Continuous: three frames, cont dropped mid third frame
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < 3; k++) begin
      f = rand_frame();
      f[0][DW-1:0] = vals[k];
      adc_q.push_back(f);
      sb.push_back(mk_exp(f, s + LAT + k*PER));
    end
    bus.cont = 1'b1;
    repeat (300) @(negedge clk);
    bus.cont = 1'b0;
    drain(600);

    // start re-pulsed mid frame must be ignored
    @(negedge clk);
    s = cyc;
    f = rand_frame();
    adc_q.push_back(f);
    sb.push_back(mk_exp(f, s + LAT));
    bus.start = 1'b1;
    @(negedge clk);
    busy_low = 0;
    for (int k = 1; k <= LAT + QC; k++) begin
      bus.start = (cyc == s + 50);
      if (!bus.busy) busy_low++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_through_frame_lowcnt", 64'(busy_low), 64'd0);
    check("busy_after_frame", bus.busy, 0);
    drain(400);

    // Asynchronous reset mid frame
    single(rand_frame());
    repeat (69) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs", cs, 1); check("midrst_sclk", sclk, 1);
    check("midrst_valid", bus.valid, 0); check("midrst_busy", bus.busy, 0);
    check("midrst_dout", bus.dout, 0);
    adc_q.delete(); sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    single(rand_frame()); drain(400);

    // Narrow instance
    single2({6'h00, 10'h2AA}); drain(200);
    single2({6'h10, 10'h155}); drain(200);
    repeat (3) begin
      single2({(($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'h00), 10'($urandom)});
      drain(200);
    end

    check("scoreboards_empty", 64'(sb.size() + sb2.size() + adc_q.size() + adc2_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
